n_bit_down_counter: RTL and testbench



---
 rtl/mac_arith_pkg.sv | 15 +
 rtl/n_bit_one_subtractor.sv | 29 ++
 rtl/n_bit_down_counter.sv | 87 ++++++++
 tb/tb_n_bit_down_counter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mac_arith_pkg.sv
// Shared definitions for the MAC arithmetic primitives: countdown FSM
// state encodings and the state type used by n_bit_down_counter.
package mac_arith_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_COUNT = 2'd1;
  localparam logic [1:0] ENC_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    COUNT = ENC_COUNT,
    DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/n_bit_one_subtractor.sv
// Combinational N-bit subtract-one: {bout, DIFF} = {1'b0, A} - bin.
// Built as a ripple of half-subtractor cells, the mirror image of the
// n_bit_one_adder incrementer.
module n_bit_one_subtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic         bin,
  output logic [N-1:0] DIFF,
  output logic         bout
);

  logic [N:0] borrow;

  // Half-subtractor ripple: each cell flips its bit when a borrow arrives
  // and passes the borrow on only while the bit was zero.
  always_comb begin
    borrow    = '0;
    DIFF      = '0;
    borrow[0] = bin;
    for (int i = 0; i < N; i++) begin
      DIFF[i]       = A[i] ^ borrow[i];
      borrow[i + 1] = ~A[i] & borrow[i];
    end
  end

  assign bout = borrow[N];

endmodule

// File: rtl/n_bit_down_counter.sv
// Loadable N-bit down-counter. A start value is accepted in IDLE, then the
// count decrements on every enabled cycle; a one-cycle done pulse (state
// DONE) marks completion. A zero start value goes straight to DONE.
//
// Load handshake: a transfer happens on a rising clk edge where
// load_valid && load_ready are both high. load_ready is high only in IDLE
// and is decoded from state, so it never depends on load_valid; a held
// load_valid outside IDLE is simply ignored until the block returns to IDLE.
module n_bit_down_counter
  import mac_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  input  logic [N-1:0] load_value,
  output logic         load_ready,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam logic [N-1:0] COUNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] count_nxt;
  logic [N-1:0] count_dec;
  logic         sub_bout_unused;

  // Decrement datapath; only used while count >= 1, so the borrow-out
  // never fires and is left dangling.
  n_bit_one_subtractor #(.N(N)) u_dec (
    .A    (count),
    .bin  (1'b1),
    .DIFF (count_dec),
    .bout (sub_bout_unused)
  );

  // State and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state and next-count: load in IDLE, decrement in COUNT, one
  // cycle in DONE then back to IDLE.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (load_valid) begin
          count_nxt = load_value;
          state_nxt = (load_value == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (en) begin
          count_nxt = count_dec;
          if (count == COUNT_ONE) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Outputs decoded from state only.
  assign load_ready = (state == IDLE);
  assign busy       = (state == COUNT) || (state == DONE);
  assign done       = (state == DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_n_bit_down_counter.sv
// Self-checking bench for n_bit_down_counter plus a standalone check of
// the n_bit_one_subtractor decrement cell.
module tb_n_bit_down_counter;
  import mac_arith_pkg::*;

  localparam int N = 8;
  localparam int W = N + 2;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         load_valid;
  logic [N-1:0] load_value;
  logic         load_ready;
  logic         en;
  logic [N-1:0] count;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  n_bit_down_counter #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .en         (en),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Standalone subtractor instance
  logic [7:0] sa;
  logic       sb;
  logic [7:0] sd;
  logic       sbo;

  n_bit_one_subtractor #(.N(8)) u_sub (
    .A    (sa),
    .bin  (sb),
    .DIFF (sd),
    .bout (sbo)
  );

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs, push the expected post-edge
  // {count, state}, then compare at the following negedge.
  task automatic step(input logic lv, input logic [N-1:0] lval, input logic e,
                      input logic rn, input logic [N-1:0] xc, input state_t xs,
                      input string tag);
    logic [W-1:0] ex;
    state_t       es;
    reset_n    = rn;
    load_valid = lv;
    load_value = lval;
    en         = e;
    exp_q.push_back({xc, xs});
    @(posedge clk);
    @(negedge clk);
    ex = exp_q.pop_front();
    es = state_t'(ex[1:0]);
    check_eq({tag, ".count"}, 32'(count), 32'(ex[W-1:2]));
    check_eq({tag, ".state"}, 32'(dbg_state), 32'(ex[1:0]));
    check_eq({tag, ".load_ready"}, 32'(load_ready), 32'(es == IDLE));
    check_eq({tag, ".busy"}, 32'(busy), 32'(es != IDLE));
    check_eq({tag, ".done"}, 32'(done), 32'(es == DONE));
  endtask

  task automatic idle_step(input logic e, input logic [N-1:0] xc, input state_t xs, input string tag);
    step(1'b0, '0, e, 1'b1, xc, xs, tag);
  endtask

  task automatic load_step(input logic [N-1:0] v, input string tag);
    step(1'b1, v, 1'b1, 1'b1, v, (v == '0) ? DONE : COUNT, tag);
  endtask

  initial begin
    logic [7:0] pat;
    logic [N-1:0] cnt;
    logic [8:0] gold;
    logic       e;

    reset_n = 1'b0; load_valid = 1'b0; load_value = '0; en = 1'b0;
    sa = '0; sb = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 8'd0, IDLE, "reset");
    idle_step(1'b1, 8'd0, IDLE, "idle_en_ignored");

    // Load 3, en held high: 3,2,1,0(done), back to IDLE
    load_step(8'd3, "t1_load");
    idle_step(1'b1, 8'd2, COUNT, "t1_c2");
    idle_step(1'b1, 8'd1, COUNT, "t1_c1");
    idle_step(1'b1, 8'd0, DONE,  "t1_done");
    idle_step(1'b1, 8'd0, IDLE,  "t1_idle");

    // Load 5 with stalls in the enable pattern
    load_step(8'd5, "t2_load");
    pat = 8'b1101_1001; // applied LSB first: 1,0,0,1,1,0,1,1
    cnt = 8'd5;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) cnt = cnt - 8'd1;
      idle_step(pat[i], cnt, (cnt == 0) ? DONE : COUNT, "t2_run");
    end
    idle_step(1'b0, 8'd0, IDLE, "t2_idle");

    // Zero-length countdown
    step(1'b1, 8'd0, 1'b0, 1'b1, 8'd0, DONE, "t3_load0");
    idle_step(1'b0, 8'd0, IDLE, "t3_idle");

    // Load attempts while counting and in DONE are ignored
    load_step(8'd4, "t4_load");
    step(1'b1, 8'd9, 1'b1, 1'b1, 8'd3, COUNT, "t4_ign3");
    step(1'b1, 8'd9, 1'b1, 1'b1, 8'd2, COUNT, "t4_ign2");
    step(1'b1, 8'd9, 1'b1, 1'b1, 8'd1, COUNT, "t4_ign1");
    step(1'b1, 8'd9, 1'b1, 1'b1, 8'd0, DONE,  "t4_done");
    step(1'b1, 8'd9, 1'b1, 1'b1, 8'd0, IDLE,  "t4_done_ign");
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, IDLE,  "t4_idle");

    // Reset in the middle of a long countdown
    load_step(8'hFF, "t5_load");
    for (int i = 0; i < 127; i++) idle_step(1'b1, 8'(8'hFE - i), COUNT, "t5_run");
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, IDLE, "t5_reset");
    idle_step(1'b0, 8'd0, IDLE, "t5_after");
    load_step(8'd2, "t5_load2");
    idle_step(1'b1, 8'd1, COUNT, "t5_c1");
    idle_step(1'b1, 8'd0, DONE,  "t5_done");
    idle_step(1'b0, 8'd0, IDLE,  "t5_idle");

    // Random loads with random enable stalls
    for (int k = 0; k < 6; k++) begin
      cnt = 8'($urandom_range(1, 12));
      load_step(cnt, "rnd_load");
      while (cnt != 0) begin
        e = 1'($urandom_range(0, 1));
        if (e) cnt = cnt - 8'd1;
        idle_step(e, cnt, (cnt == 0) ? DONE : COUNT, "rnd_run");
      end
      idle_step(1'b0, 8'd0, IDLE, "rnd_idle");
    end

    // Standalone subtractor: directed corners then random vectors
    sa = 8'h00; sb = 1'b1; #1;
    check_eq("sub_0m1", 32'({sbo, sd}), 32'h1FF);
    sa = 8'h80; sb = 1'b1; #1;
    check_eq("sub_80m1", 32'({sbo, sd}), 32'h07F);
    sa = 8'h05; sb = 1'b0; #1;
    check_eq("sub_5m0", 32'({sbo, sd}), 32'h005);
    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom_range(0, 255));
      sb = 1'($urandom_range(0, 1));
      #1;
      gold = {1'b0, sa} - {8'd0, sb};
      check_eq("sub_rnd", 32'({sbo, sd}), 32'(gold));
    end

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
